// File: rtl/bsc_axiu_pkg.sv
// Shared definitions for the AXI utility adapters: bus width, FIFO entry layout
// and elaboration-time sizing helpers.
package bsc_axiu_pkg;

  localparam int AXIU_DATA_W = 64;
  localparam int AXIU_CNT_W  = 16;

  typedef struct packed {
    logic                   last;
    logic [AXIU_DATA_W-1:0] data;
  } axiu_ent_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsc_axiu_hstostreamadapter_if.sv
// ap_hs input side and AXI4-Stream output side of the adapter, bundled.
// The adapter drives through 'master' (it is the stream master).
interface bsc_axiu_hstostreamadapter_if;
  import bsc_axiu_pkg::*;

  logic [AXIU_DATA_W-1:0] in_hs;
  logic                   in_hs_ap_vld;
  logic                   in_hs_ap_ack;
  logic [AXIU_DATA_W-1:0] outStream_tdata;
  logic                   outStream_tvalid;
  logic                   outStream_tready;
  logic                   outStream_tlast;

  modport master (
    input  in_hs, in_hs_ap_vld, outStream_tready,
    output in_hs_ap_ack, outStream_tdata, outStream_tvalid, outStream_tlast
  );

  modport slave (
    output in_hs, in_hs_ap_vld, outStream_tready,
    input  in_hs_ap_ack, outStream_tdata, outStream_tvalid, outStream_tlast
  );

endinterface

// File: rtl/bsc_axiu_syncFifo.sv
// Register-array FIFO; pointers/count reset asynchronously, storage is not reset.
// Writes while full and reads while empty are ignored.
module bsc_axiu_syncFifo
  import bsc_axiu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("bsc_axiu_syncFifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_wr, w_rd;

  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bsc_axiu_hstostreamadapter.sv
// ap_hs producer -> 64-bit AXI4-Stream master through an elastic FIFO, with an
// optional TLAST every PKT_WORDS words tagged at push time.
module bsc_axiu_hstostreamadapter
  import bsc_axiu_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PKT_WORDS = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  bsc_axiu_hstostreamadapter_if.master   io
);

  localparam int ENT_W = $bits(axiu_ent_t);

  if (PKT_WORDS < 0 || PKT_WORDS > 65535) begin : g_bad_pkt
    $error("bsc_axiu_hstostreamadapter: PKT_WORDS out of range 0..65535");
  end

  logic      w_full, w_empty;
  logic      w_push, w_pop, w_last;
  axiu_ent_t w_wr_ent, w_rd_ent;

  // No bypass: ack only looks at the registered full flag, never at tready.
  assign w_push = io.in_hs_ap_vld & ~w_full & aresetn;
  assign w_pop  = ~w_empty & io.outStream_tready;

  assign w_wr_ent = '{last: w_last, data: io.in_hs};

  assign io.in_hs_ap_ack     = w_push;
  assign io.outStream_tvalid = ~w_empty;
  assign io.outStream_tdata  = w_rd_ent.data;
  assign io.outStream_tlast  = w_rd_ent.last;

  if (PKT_WORDS > 0) begin : g_wcnt
    logic [AXIU_CNT_W-1:0] r_wcnt;

    assign w_last = (r_wcnt == AXIU_CNT_W'(PKT_WORDS - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)    r_wcnt <= '0;
      else if (w_push) r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
    end
  end else begin : g_no_wcnt
    assign w_last = 1'b0;
  end

  bsc_axiu_syncFifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_push),
    .i_wdata (w_wr_ent),
    .i_pop   (w_pop),
    .o_rdata (w_rd_ent),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_bsc_axiu_hstostreamadapter.sv
// Two adapters (DEPTH=2/no TLAST and DEPTH=4/PKT_WORDS=4) on shared stimulus,
// each checked every cycle against a queue model, plus directed literal checks.
module tb_bsc_axiu_hstostreamadapter;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } ent_t;

  logic        aclk = 1'b0;
  logic        rst_n;
  logic [63:0] hs;
  logic        vld, rdy;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  bsc_axiu_hstostreamadapter_if ifa ();
  bsc_axiu_hstostreamadapter_if ifb ();

  assign ifa.in_hs            = hs;
  assign ifa.in_hs_ap_vld     = vld;
  assign ifa.outStream_tready = rdy;
  assign ifb.in_hs            = hs;
  assign ifb.in_hs_ap_vld     = vld;
  assign ifb.outStream_tready = rdy;

  bsc_axiu_hstostreamadapter #(.DEPTH(2), .PKT_WORDS(0)) u0 (
    .aclk (aclk), .aresetn (rst_n), .io (ifa)
  );
  bsc_axiu_hstostreamadapter #(.DEPTH(4), .PKT_WORDS(4)) u1 (
    .aclk (aclk), .aresetn (rst_n), .io (ifb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural models ----------------
  ent_t        q0[$], q1[$];
  int          n1 = 0;         // pushes into u1 since last reset
  int          pops0 = 0;
  logic [63:0] lastq[$];       // u1 words leaving with tlast set
  bit          p0, r0, p1, r1;
  ent_t        e0, e1;

  always @(negedge aclk) begin
    if (!rst_n) begin
      chk("u0_rst_tvalid", ifa.outStream_tvalid, 0);
      chk("u0_rst_ack", ifa.in_hs_ap_ack, 0);
      q0.delete();
    end else begin
      p0 = vld && (q0.size() < 2);
      r0 = (q0.size() > 0) && rdy;
      chk("u0_ack", ifa.in_hs_ap_ack, p0);
      chk("u0_tvalid", ifa.outStream_tvalid, q0.size() > 0);
      if (q0.size() > 0) begin
        chk("u0_tdata", ifa.outStream_tdata, q0[0].d);
        chk("u0_tlast", ifa.outStream_tlast, q0[0].l);
      end
      if (r0) begin
        void'(q0.pop_front());
        pops0++;
      end
      if (p0) begin
        e0.d = hs; e0.l = 1'b0;
        q0.push_back(e0);
      end
    end
  end

  always @(negedge aclk) begin
    if (!rst_n) begin
      chk("u1_rst_tvalid", ifb.outStream_tvalid, 0);
      chk("u1_rst_ack", ifb.in_hs_ap_ack, 0);
      q1.delete();
      n1 = 0;
    end else begin
      p1 = vld && (q1.size() < 4);
      r1 = (q1.size() > 0) && rdy;
      chk("u1_ack", ifb.in_hs_ap_ack, p1);
      chk("u1_tvalid", ifb.outStream_tvalid, q1.size() > 0);
      if (q1.size() > 0) begin
        chk("u1_tdata", ifb.outStream_tdata, q1[0].d);
        chk("u1_tlast", ifb.outStream_tlast, q1[0].l);
      end
      if (r1) begin
        if (q1[0].l) lastq.push_back(q1[0].d);
        void'(q1.pop_front());
      end
      if (p1) begin
        e1.d = hs; e1.l = ((n1 % 4) == 3);
        q1.push_back(e1);
        n1++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic drain(input int n);
    vld = 1'b0; rdy = 1'b1;
    repeat (n) step();
  endtask

  task automatic push_u1(input logic [63:0] d);
    bit got;
    hs = d; vld = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge aclk);
      got = ifb.in_hs_ap_ack;
      step();
    end
    if (!got) chk("u1_push_timeout", got, 1);
    vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit done;
    rst_n = 1'b0; vld = 1'b0; rdy = 1'b0; hs = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single word
    hs = 64'hDEADBEEF_00000001; vld = 1'b1; rdy = 1'b1;
    @(negedge aclk); chk("single_ack", ifa.in_hs_ap_ack, 1);
    step(); vld = 1'b0;
    @(negedge aclk);
    chk("single_tvalid", ifa.outStream_tvalid, 1);
    chk("single_tdata", ifa.outStream_tdata, 64'hDEADBEEF_00000001);
    chk("single_tlast", ifa.outStream_tlast, 0);
    step();

    // Backpressure fill on the DEPTH=2 instance
    rdy = 1'b0; hs = 64'd1; vld = 1'b1;
    @(negedge aclk); chk("bp_ack_c1", ifa.in_hs_ap_ack, 1);
    step(); hs = 64'd2;
    @(negedge aclk); chk("bp_ack_c2", ifa.in_hs_ap_ack, 1);
    chk("bp_tdata_c2", ifa.outStream_tdata, 64'd1);
    step(); hs = 64'd3;
    @(negedge aclk); chk("bp_ack_c3", ifa.in_hs_ap_ack, 0);
    step();
    @(negedge aclk); chk("bp_ack_c4", ifa.in_hs_ap_ack, 0);
    chk("bp_hold_tvalid", ifa.outStream_tvalid, 1);
    chk("bp_hold_tdata", ifa.outStream_tdata, 64'd1);
    step(); rdy = 1'b1;
    @(negedge aclk); chk("bp_pop1_ack", ifa.in_hs_ap_ack, 0);
    chk("bp_pop1_tdata", ifa.outStream_tdata, 64'd1);
    step();
    @(negedge aclk); chk("bp_pop2_ack", ifa.in_hs_ap_ack, 1);
    chk("bp_pop2_tdata", ifa.outStream_tdata, 64'd2);
    step(); vld = 1'b0;
    @(negedge aclk); chk("bp_pop3_tdata", ifa.outStream_tdata, 64'd3);
    drain(10);

    // Streaming 0..99 at full rate
    base = pops0;
    rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      hs = 64'(i); vld = 1'b1;
      @(negedge aclk); chk("stream_ack", ifa.in_hs_ap_ack, 1);
      step();
    end
    drain(10);
    chk("stream_count", 64'(pops0 - base), 64'd100);

    // TLAST every 4 words with toggling tready
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
    lastq.delete();
    done = 1'b0; rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) push_u1(64'(i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          rdy = ~rdy;
        end
      end
    join
    drain(12);
    chk("tlast_count", 64'(lastq.size()), 64'd3);
    if (lastq.size() == 3) begin
      chk("tlast_w0", lastq[0], 64'd3);
      chk("tlast_w1", lastq[1], 64'd7);
      chk("tlast_w2", lastq[2], 64'd11);
    end

    // Mid-operation asynchronous reset with two words held
    rdy = 1'b0; vld = 1'b1; hs = 64'd100;
    step(); hs = 64'd101;
    step(); vld = 1'b0;
    #1;
    chk("mid_pre_tvalid", ifa.outStream_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid_u0", ifa.outStream_tvalid, 0);
    chk("mid_rst_tvalid_u1", ifb.outStream_tvalid, 0);
    step();
    rst_n = 1'b1;
    step();
    rdy = 1'b1; hs = 64'd55; vld = 1'b1;
    @(negedge aclk); chk("mid_post_ack", ifb.in_hs_ap_ack, 1);
    step(); vld = 1'b0;
    @(negedge aclk);
    chk("mid_post_tvalid", ifb.outStream_tvalid, 1);
    chk("mid_post_tdata", ifb.outStream_tdata, 64'd55);
    chk("mid_post_tlast", ifb.outStream_tlast, 0);
    drain(4);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      vld = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      hs  = {$urandom, $urandom};
      step();
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsc_axiu_hstostreamadapter.md
Name: bsc_axiu_hsToStreamAdapter

Overview:
- Converts an HLS ap_hs output port (data + ap_vld, expects ap_ack) into a 64-bit AXI4-Stream master.
- Inverse of the stream-to-handshake adapter; placed between accelerator ap_hs outputs and the stream interconnect.
- Contains a small elastic FIFO so that a stalled stream does not throttle the accelerator for up to DEPTH words.
- Optionally generates TLAST every PKT_WORDS words.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- PKT_WORDS, 0, words per packet for TLAST; 0 = TLAST always low; 1 = every word last; max 65535.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_hs  in  64  handshake data from the accelerator.
- in_hs_ap_vld  in  1  in_hs valid.
- in_hs_ap_ack  out  1  word accepted this cycle.
- outStream_tdata  out  64  stream data.
- outStream_tvalid  out  1  stream valid.
- outStream_tready  in  1  stream ready.
- outStream_tlast  out  1  packet end marker.

Behaviour:
- Reset: aclk only; aresetn is asynchronous and active-low. While asserted, the FIFO is empty (rd/wr pointers = 0, count = 0), the word counter is 0, outStream_tvalid = 0 and in_hs_ap_ack = 0. outStream_tdata and tlast are don't-care but must not be X-dependent on control. Deassertion is taken synchronously to aclk by the upstream reset bridge.
- Push: in_hs_ap_ack = in_hs_ap_vld & ~full. ack is combinational from vld and the registered full flag. push = ack. No bypass: a word is never accepted while full, even if a pop occurs in the same cycle.
- Pop:
  - outStream_tvalid = ~empty (registered flags).
  - tdata and tlast come from the head entry.
  - pop = tvalid & tready.
- Latency: a word acked in cycle N is visible on outStream in cycle N+1 (tvalid = 1) when the FIFO was empty. Throughput is 1 word/cycle sustained when tready = 1.
- AXI rules:
  - tvalid, once high, stays high with tdata and tlast stable until tready.
  - tvalid never depends combinationally on tready.
- FIFO: count 0..DEPTH, clog2(DEPTH)+1 bits; pointers clog2(DEPTH) bits with natural wrap.
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, both pointers advance.
  - full = (count == DEPTH); empty = (count == 0).
- TLAST generation, with PKT_WORDS > 0:
  - A 16-bit word counter increments on each push.
  - The pushed entry is tagged last = (wcnt == PKT_WORDS-1), and in that case wcnt wraps to 0.
  - The tag is stored per entry so that TLAST is correct regardless of backpressure.
  - With PKT_WORDS == 0 the tag is always 0 and the counter is not synthesised.
- Reset mid-operation: asserting aresetn drops tvalid and flushes the FIFO immediately (asynchronously). The word counter also returns to 0, so the next packet starts fresh.
- Elaboration: an illegal DEPTH (not a power of two, or < 2) is an elaboration error.

Decomposition:
- Shared package bsc_axiu_pkg: AXIU_DATA_W = 64, plus the clog2 helper function.
- Sub-module bsc_axiu_syncFifo (DATA_W, DEPTH): register-array FIFO with full/empty/count, async active-low reset on control only. The adapter holds the ack logic and the TLAST counter, and stores {last, data} as 65-bit entries.

Test Plan:
- Single word: reset, then drive vld = 1 with in_hs = 0xDEADBEEF_00000001 for one cycle, tready = 1 -> ack = 1 in that cycle; tvalid = 1 with that tdata next cycle; tlast = 0 (PKT_WORDS = 0).
- Backpressure fill, DEPTH = 2: vld held high with values 1, 2, 3, tready = 0 -> ack is high for 2 cycles then low; tvalid stays 1 with tdata = 1. Raise tready -> outputs 1 then 2; value 3 is acked one cycle after the first pop and emitted in order.
- Streaming: 100 consecutive words 0..99 with vld = 1, tready = 1 -> 1 word/cycle, ack never drops, output order exact.
- TLAST, PKT_WORDS = 4: push words 0..11 while tready toggles 1,0,1,0 -> tlast = 1 exactly on words 3, 7 and 11.
- Mid-operation reset: FIFO holding 2 words, aresetn pulsed low between clock edges -> tvalid = 0 immediately. After release, push one word with PKT_WORDS = 4: it is tagged tlast = 0 and the counter restarts at 0.
- Random stimulus: random vld and tready over 10k cycles, checked against a scoreboard -> no loss, duplication or reorder; tvalid/tdata stable while stalled.
